led_fader: RTL
==============

# led_fader

Per-LED brightness fader sitting directly downstream of the SoC's `leds_out` port on the board top level. Each LED bit from the SoC is a target (on/off); the block ramps a per-LED brightness up or down at a fixed rate and drives the pins with PWM, so LED changes fade rather than snap. Optionally it ORs the SoC PWM peripheral output into LED 0, replacing the OR gate at the top level.

## Interface

- `N_LEDS`, 8, number of LED channels.
- `PWM_BITS`, 8, brightness and PWM counter width; max brightness `BMAX = 2^PWM_BITS-1`.
- `FADE_DIV`, 50000, clock cycles per brightness step, ≥1. The prescaler is `$clog2(FADE_DIV)` bits wide, minimum 1.

- `clk`  in  1  system clock; same clock as the SoC (`clk_50`).
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `leds_in`  in  N_LEDS  target state per LED from the SoC `leds_out`.
- `pwm_in`  in  1  SoC PWM peripheral output. Used only with the configuration macro.
- `leds_out`  out  N_LEDS  LED pin drive, registered.

## Operation

- `tgt`: register of `leds_in`, updated every cycle.
- Prescaler `div`:
  - Counts 0..FADE_DIV-1 and wraps to 0.
  - `tick` is asserted in the cycle `div == FADE_DIV-1`.
  - With FADE_DIV=1, `tick` is asserted every cycle.
- PWM counter `pcnt`: PWM_BITS wide, increments every cycle, wraps BMAX→0. It is free-running and independent of `tick`.
- Brightness `b[i]`: PWM_BITS wide, one per LED. It changes only on `tick`:
  - If `tgt[i]=1` and `b[i]<BMAX`, then `b[i]+1`.
  - If `tgt[i]=0` and `b[i]>0`, then `b[i]-1`.
  - Otherwise it holds. It saturates at both ends and never wraps.
- Target change mid-fade: the direction reverses at the next `tick` from the current `b[i]`. There is no restart from an end value.
- Output per channel: `leds_out[i] <= (b[i]==BMAX) | (b[i] > pcnt)`.
  - `b=0` gives a constant 0.
  - `b=BMAX` gives a constant 1.
  - Otherwise the duty cycle is `b/2^PWM_BITS`.
- All channels share `div` and `pcnt`, so they are phase-aligned.
- Async reset sets `tgt`, `div`, `pcnt`, every `b[i]`, and `leds_out` to 0.
  - Reset asserted mid-fade aborts the fade.
  - After release, fades restart from 0 toward the current `leds_in`.

## Timing

- `leds_in` → `tgt`: 1 cycle.
- `tgt` → first `b` change: at the next `tick`. Worst case FADE_DIV cycles; with `div` aligned, this can be the same edge as the `tgt` update plus 1.
- `b`/`pcnt` → `leds_out`: 1 cycle (registered).
- Full-scale fade (0→BMAX or BMAX→0): BMAX ticks = BMAX×FADE_DIV cycles. With the defaults at 50 MHz: 255×50000 = 12.75 M cycles ≈ 255 ms.
- PWM period: 2^PWM_BITS cycles. With the defaults at 50 MHz this is 195.3 kHz.
- First rising edge after reset release: `div`=1 and `pcnt`=1. `leds_out` is 0 until some `b[i]` becomes nonzero.

## Configuration

- `LED_FADER_PWM_MIX_EN` defined:
  - `leds_out[0] <= fade_out[0] | pwm_in`.
  - `pwm_in` passes through with 1 cycle of latency and no fading.
- `LED_FADER_PWM_MIX_EN` undefined:
  - `pwm_in` is unconnected internally and ignored.
  - `leds_out[0]` is the faded channel only.
  - The top level performs any mixing.

## Test plan

Bench parameters: N_LEDS=8, PWM_BITS=4 (BMAX=15), FADE_DIV=4.

- Reset: hold `rst`=1 with `leds_in`=8'hFF and `pwm_in` toggling → `leds_out`=0 throughout, including the macro build. Release → `b[*]` reach 15 after 15 ticks (60 cycles ±4).
- Fade up: `leds_in` goes 0→8'h01 → `b[0]` increments by 1 every 4 cycles. The duty of `leds_out[0]` over each 16-cycle window equals `b[0]`/16. After `b[0]`=15, `leds_out[0]` is constant 1. Other bits stay 0.
- Reversal: at `b[0]`=7, set `leds_in`=0 → the next tick gives 6, then down to 0. The result is constant 0 and `b[0]` never underflows to 15.
- Saturation: hold `leds_in`=8'hAA for 200 cycles → `b` of the odd bits is pinned at 15 and the even bits at 0. `leds_out`=8'hAA constant.
- Reset mid-fade: assert `rst` asynchronously (not clock-aligned) at `b[3]`=9 → `leds_out` goes to 0 immediately. After release, `b[3]` ramps from 0.
- Macro build: with `LED_FADER_PWM_MIX_EN`, `leds_in`=0, `pwm_in`=1 → `leds_out[0]`=1 one cycle later. `pwm_in`=0 → 0 one cycle later. Without the macro → `leds_out[0]` stays 0.

Source files
------------

// File: rtl/led_fader.sv
// led_fader: per-LED brightness fader; each leds_in bit is an on/off target, brightness ramps one step per tick and drives the pins through PWM.
//   Ports: clk (system clock), rst (async active-high reset), leds_in[N_LEDS] (per-LED targets),
//          pwm_in (SoC PWM output, mixed into LED 0 only when LED_FADER_PWM_MIX_EN is defined),
//          leds_out[N_LEDS] (registered LED pin drive).
//   Optional feature macro: LED_FADER_PWM_MIX_EN.
module led_fader #(
   parameter int N_LEDS   = 8,
   parameter int PWM_BITS = 8,
   parameter int FADE_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_LEDS-1:0] leds_in,
   input  logic              pwm_in,
   output logic [N_LEDS-1:0] leds_out
);
   localparam int DIV_W = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);
   localparam logic [PWM_BITS-1:0] BMAX = '1;
   logic [N_LEDS-1:0]   tgt_q, tgt_d, leds_out_q, leds_out_d, fade_out;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
   logic [PWM_BITS-1:0] b_q [N_LEDS];
   logic [PWM_BITS-1:0] b_d [N_LEDS];
   logic                tick;
   always_comb begin
      tick   = div_q == DIV_LAST;
      div_d  = tick ? '0 : div_q + 1'b1;
      pcnt_d = pcnt_q + 1'b1;
      tgt_d  = leds_in;
      for (int i = 0; i < N_LEDS; i++) begin
         // Saturating step toward the target; a target flip mid-fade simply reverses from the current level.
         b_d[i] = !tick                        ? b_q[i] :
                  (tgt_q[i] && b_q[i] != BMAX) ? b_q[i] + 1'b1 :
                  (!tgt_q[i] && b_q[i] != '0)  ? b_q[i] - 1'b1 : b_q[i];
         // Full scale is forced on so BMAX is a steady 1 rather than 15/16 duty.
         fade_out[i] = (b_q[i] == BMAX) | (b_q[i] > pcnt_q);
      end
      leds_out_d = fade_out;
`ifdef LED_FADER_PWM_MIX_EN
      leds_out_d[0] = fade_out[0] | pwm_in;
`endif
   end
`ifndef LED_FADER_PWM_MIX_EN
   logic unused_pwm;
   assign unused_pwm = pwm_in;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgt_q      <= '0;
         div_q      <= '0;
         pcnt_q     <= '0;
         leds_out_q <= '0;
         for (int i = 0; i < N_LEDS; i++) b_q[i] <= '0;
      end else begin
         tgt_q      <= tgt_d;
         div_q      <= div_d;
         pcnt_q     <= pcnt_d;
         leds_out_q <= leds_out_d;
         for (int i = 0; i < N_LEDS; i++) b_q[i] <= b_d[i];
      end
   end
   assign leds_out = leds_out_q;
endmodule
